uart_rx_param_fifo: RTL
=======================

UART_RX_PARAM_FIFO -- requirements
Module: uart_rx_param_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clocks per serial bit (>=4).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..9).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have port i_Clock  in  1  meaning sole clock, all logic on rising edge.
REQ-005 SHALL have port i_Reset  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port i_Rx_Serial  in  1  meaning asynchronous serial line, idle high.
REQ-007 SHALL have port i_Parity_Mode  in  2  meaning 00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 SHALL have port i_Read_Flag  in  1  meaning pop request for FIFO head.
REQ-009 SHALL have port i_Clear_Err  in  1  meaning clear all sticky error flags.
REQ-010 SHALL have port o_Rx_Byte  out  DATA_BITS  meaning FIFO head data, show-ahead.
REQ-011 SHALL have port o_Rx_DV  out  1  meaning one-cycle pulse per byte written to FIFO.
REQ-012 SHALL have ports o_Empty, o_Full  out  1 each  meaning FIFO status.
REQ-013 SHALL have port o_Count  out  clog2(FIFO_DEPTH)+1  meaning stored entries.
REQ-014 SHALL have ports o_Parity_Err, o_Frame_Err, o_Overrun  out  1 each  meaning sticky error flags.
REQ-015 SHALL have port r_SM_Main  out  3  meaning current receiver state encoding.

Function
REQ-016 SHALL pass i_Rx_Serial through a 2-flop synchronizer; both flops reset to 1.
REQ-017 SHALL implement states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, CLEANUP=5.
REQ-018 IDLE: on synchronized line low, SHALL go to START with bit counter cleared.
REQ-019 START: at count (CLKS_PER_BIT-1)/2 SHALL resample; low -> DATA with counter cleared; high -> IDLE (glitch reject, no flags).
REQ-020 DATA: SHALL sample every CLKS_PER_BIT clocks, LSB first, DATA_BITS samples, then PARITY if mode 01/10 else STOP.
REQ-021 PARITY: SHALL sample one bit; mismatch against even/odd parity of payload marks frame bad-parity.
REQ-022 STOP: SHALL sample one bit; 0 marks frame bad-framing; then CLEANUP.
REQ-023 CLEANUP: single cycle; SHALL push good frame, set flags for bad frame, return to IDLE.
REQ-024 Bad-parity frame SHALL set o_Parity_Err and NOT be pushed; bad-framing SHALL set o_Frame_Err and NOT be pushed; both may set together.
REQ-025 Good frame with FIFO full and no same-cycle pop SHALL be dropped and set o_Overrun; FIFO contents unchanged.
REQ-026 Good frame with FIFO full and same-cycle pop SHALL be accepted; o_Count unchanged.
REQ-027 o_Rx_DV SHALL pulse in the cycle after CLEANUP, only when the byte was written.
REQ-028 Pop SHALL occur on i_Read_Flag high with o_Empty low; o_Rx_Byte shows new head the next cycle.
REQ-029 i_Read_Flag with o_Empty high SHALL be ignored without error.
REQ-030 Simultaneous push and pop when not empty/full SHALL keep o_Count constant; when empty, pop is ignored and push proceeds.
REQ-031 Pointers SHALL wrap modulo FIFO_DEPTH; o_Full = (o_Count==FIFO_DEPTH), o_Empty = (o_Count==0).
REQ-032 i_Clear_Err SHALL clear all sticky flags next cycle; an error set in the same cycle SHALL win.
REQ-033 i_Parity_Mode SHALL be latched at START entry; changes mid-frame do not affect that frame.

Reset
REQ-034 On i_Reset high, immediately and regardless of clock: state IDLE, counters 0, FIFO pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Rx_DV 0, all error flags 0, o_Rx_Byte 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; after release the receiver waits for a fresh line-high-to-low transition.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, FIFO_DEPTH=8)
REQ-036 Mode 00, send 0xC9 with stop=1 -> o_Rx_DV pulse once, o_Rx_Byte=0xC9, o_Count=1, no flags.
REQ-037 Mode 01, send 0x05 parity=0 then 0x11 parity=1 -> 0x05 stored, 0x11 dropped, o_Parity_Err=1, o_Count=1.
REQ-038 Mode 10, send 0xA5 stop=0 -> nothing stored, o_Frame_Err=1; i_Clear_Err pulse -> flag 0.
REQ-039 Send 9 good bytes 0x00..0x08, no pops -> o_Full=1 after 8th, 9th dropped, o_Overrun=1; 8 pops return 0x00..0x07 in order, o_Empty=1.
REQ-040 Low glitch of 1 clock on idle line -> state returns to IDLE, no DV, no flags.
REQ-041 Assert i_Reset during DATA of 0x3C -> all outputs at reset values; next full frame 0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_param_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_param_fifo
//
// UART receiver with configurable payload width and optional parity. Accepted
// frames are queued in a show-ahead receive FIFO. Frames with bad parity or a
// bad stop bit are discarded and flagged.
//
// Parameters
//   CLKS_PER_BIT  clocks per serial bit (>= 4)
//   DATA_BITS     payload bits per frame (5..9)
//   FIFO_DEPTH    receive FIFO entries (power of 2, >= 2)
//
// Ports
//   i_Clock        sole clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Rx_Serial    asynchronous serial line, idle high
//   i_Parity_Mode  00 none, 01 even, 10 odd, 11 none (sampled at frame start)
//   i_Read_Flag    pop the FIFO head (ignored when empty)
//   i_Clear_Err    clear all sticky error flags
//   o_Rx_Byte      FIFO head data (zero while empty)
//   o_Rx_DV        one-cycle pulse for each byte written into the FIFO
//   o_Empty/o_Full FIFO status
//   o_Count        number of stored entries
//   o_Parity_Err   sticky: a frame failed its parity check
//   o_Frame_Err    sticky: a frame had a low stop bit
//   o_Overrun      sticky: a good frame was dropped because the FIFO was full
//   r_SM_Main      receiver state encoding
// ---------------------------------------------------------------------------
module uart_rx_param_fifo #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Rx_Serial,
    input  logic [1:0]                    i_Parity_Mode,
    input  logic                          i_Read_Flag,
    input  logic                          i_Clear_Err,
    output logic [DATA_BITS-1:0]          o_Rx_Byte,
    output logic                          o_Rx_DV,
    output logic                          o_Empty,
    output logic                          o_Full,
    output logic [$clog2(FIFO_DEPTH):0]   o_Count,
    output logic                          o_Parity_Err,
    output logic                          o_Frame_Err,
    output logic                          o_Overrun,
    output logic [2:0]                    r_SM_Main
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic [CNT_W-1:0]       clk_count;
    logic [IDX_W-1:0]       bit_index;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [1:0]             parity_mode;
    logic                   parity_bad;
    logic                   frame_bad;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CW-1:0]          count;

    logic                   parity_en;
    logic                   expected_parity;
    logic                   frame_done;
    logic                   frame_good;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign r_SM_Main = state;

    // Two-flop synchronizer; resets to the idle line level so that reset
    // release never looks like a start bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    // Parity is only checked for modes 01 and 10. Even parity expects the
    // parity bit to equal the XOR of the payload; odd expects its inverse,
    // which is exactly what mode bit 1 adds in.
    assign parity_en       = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign expected_parity = (^shift_reg) ^ parity_mode[1];

    // Receiver state machine. The start bit is re-checked half a bit in to
    // reject glitches; every later bit is sampled one full bit period after
    // the previous sample, which lands near the centre of each bit.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            clk_count   <= '0;
            bit_index   <= '0;
            shift_reg   <= '0;
            parity_mode <= 2'b00;
            parity_bad  <= 1'b0;
            frame_bad   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_count <= '0;
                    bit_index <= '0;
                    if (!rx_sync) begin
                        state       <= START;
                        parity_mode <= i_Parity_Mode;
                        parity_bad  <= 1'b0;
                        frame_bad   <= 1'b0;
                    end
                end

                START: begin
                    if (clk_count == HALF_BIT) begin
                        clk_count <= '0;
                        state     <= rx_sync ? IDLE : DATA;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_count != BIT_LAST) begin
                        clk_count <= clk_count + 1'b1;
                    end else begin
                        clk_count            <= '0;
                        shift_reg[bit_index] <= rx_sync;
                        if (bit_index == IDX_LAST) begin
                            bit_index <= '0;
                            state     <= parity_en ? PARITY : STOP;
                        end else begin
                            bit_index <= bit_index + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (clk_count != BIT_LAST) begin
                        clk_count <= clk_count + 1'b1;
                    end else begin
                        clk_count  <= '0;
                        parity_bad <= (rx_sync != expected_parity);
                        state      <= STOP;
                    end
                end

                STOP: begin
                    if (clk_count != BIT_LAST) begin
                        clk_count <= clk_count + 1'b1;
                    end else begin
                        clk_count <= '0;
                        frame_bad <= ~rx_sync;
                        state     <= CLEANUP;
                    end
                end

                CLEANUP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A full FIFO can still take a frame when the head is popped in the same
    // cycle: the freed slot is the one the write pointer already points at.
    assign frame_done = (state == CLEANUP);
    assign frame_good = frame_done && !parity_bad && !frame_bad;
    assign pop        = i_Read_Flag && !o_Empty;
    assign push       = frame_good && (!o_Full || pop);
    assign drop       = frame_good && o_Full && !pop;

    assign o_Empty   = (count == '0);
    assign o_Full    = (count == DEPTH_CNT);
    assign o_Count   = count;
    assign o_Rx_Byte = o_Empty ? '0 : mem[rd_ptr];

    // FIFO storage needs no reset; the empty gate above hides stale entries.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_Rx_DV <= 1'b0;
        end else begin
            o_Rx_DV <= push;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear wins.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Overrun    <= 1'b0;
        end else begin
            o_Parity_Err <= (frame_done && parity_bad) || (o_Parity_Err && !i_Clear_Err);
            o_Frame_Err  <= (frame_done && frame_bad)  || (o_Frame_Err  && !i_Clear_Err);
            o_Overrun    <= drop                       || (o_Overrun    && !i_Clear_Err);
        end
    end

endmodule
